// File: rtl/sample_fifo_core.sv
// -----------------------------------------------------------------------------
// sample_fifo_core
// Captures a 16-bit sample stream into a circular FIFO, with optional
// decimation, and exposes it through a small slot register interface.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous, active-high
//   cs         slot select
//   read       slot read strobe (reads have no side effect)
//   write      slot write strobe
//   addr       slot register address, only addr[1:0] decoded
//   rd_data    slot read data, combinational from registered state
//   wr_data    slot write data
//   din        sample stream data
//   din_valid  one-cycle sample strobe
//
// Register map (addr[1:0]):
//   0 STATUS  R: [15:0] head, [16] empty, [17] full, [18] overflow,
//                [20+FIFO_DEPTH_BIT:20] level
//   1 CTRL    R/W: [31:16] decim, [0] enable (write also zeroes the counter)
//   2 POP     W: drop the head entry
//   3 CLEAR   W: empty FIFO, clear overflow, zero the counter
// -----------------------------------------------------------------------------
module sample_fifo_core #(
   parameter int unsigned FIFO_DEPTH_BIT = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        read,
   input  logic        write,
   input  logic [4:0]  addr,
   output logic [31:0] rd_data,
   input  logic [31:0] wr_data,
   input  logic [15:0] din,
   input  logic        din_valid
);

   localparam int unsigned PTR_W  = FIFO_DEPTH_BIT;
   localparam int unsigned LVL_W  = FIFO_DEPTH_BIT + 1;
   localparam int unsigned DEPTH  = 2 ** FIFO_DEPTH_BIT;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned DEC_W  = 16;

   localparam logic [1:0] ADDR_STATUS = 2'd0;
   localparam logic [1:0] ADDR_CTRL   = 2'd1;
   localparam logic [1:0] ADDR_POP    = 2'd2;
   localparam logic [1:0] ADDR_CLEAR  = 2'd3;

   // Registered state
   logic              enable;
   logic [DEC_W-1:0]  decim;
   logic [DEC_W-1:0]  dec_cnt;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LVL_W-1:0]  level;
   logic              overflow;
   logic [DATA_W-1:0] mem [DEPTH];

   // Decoded strobes and next-state controls
   logic              reg_wr;
   logic              ctrl_wr;
   logic              pop_wr;
   logic              clear_wr;
   logic              fifo_empty;
   logic              fifo_full;
   logic              capture;
   logic              push_req;
   logic              pop_ok;
   logic              push_ok;
   logic              ovf_set;
   logic [DATA_W-1:0] head;

   // Inputs that carry no meaning for this block
   logic unused_bits;
   assign unused_bits = ^{read, addr[4:2], wr_data[15:1]};

   // Register decode and FIFO push/pop arbitration
   always_comb begin
      reg_wr     = cs & write;
      ctrl_wr    = reg_wr & (addr[1:0] == ADDR_CTRL);
      pop_wr     = reg_wr & (addr[1:0] == ADDR_POP);
      clear_wr   = reg_wr & (addr[1:0] == ADDR_CLEAR);
      fifo_empty = (level == '0);
      fifo_full  = (level == LVL_W'(DEPTH));

      // A CTRL or CLEAR write in the same cycle consumes the sample.
      capture    = enable & din_valid & ~ctrl_wr & ~clear_wr;
      push_req   = capture & (dec_cnt == decim);

      pop_ok     = pop_wr & ~fifo_empty & ~clear_wr;
      // A pop in the same cycle frees the slot, so a full FIFO can still accept.
      push_ok    = push_req & (~fifo_full | pop_ok);
      ovf_set    = push_req & fifo_full & ~pop_ok;
   end

   // Control, decimation counter, pointers, level and overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         enable   <= 1'b0;
         decim    <= '0;
         dec_cnt  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else if (clear_wr) begin
         dec_cnt  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            enable  <= wr_data[0];
            decim   <= wr_data[31:16];
            dec_cnt <= '0;
         end else if (capture) begin
            if (dec_cnt == decim) begin
               dec_cnt <= '0;
            end else begin
               dec_cnt <= dec_cnt + DEC_W'(1);
            end
         end

         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end

         case ({push_ok, pop_ok})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase

         if (ovf_set) begin
            overflow <= 1'b1;
         end
      end
   end

   // Sample storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (!reset && push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // Read mux, purely from registered state
   always_comb begin
      head    = fifo_empty ? '0 : mem[rd_ptr];
      rd_data = '0;
      case (addr[1:0])
         ADDR_STATUS: begin
            rd_data[15:0]         = head;
            rd_data[16]           = fifo_empty;
            rd_data[17]           = fifo_full;
            rd_data[18]           = overflow;
            rd_data[20 +: LVL_W]  = level;
         end
         ADDR_CTRL: begin
            rd_data = {decim, 15'b0, enable};
         end
         default: begin
            rd_data = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_sample_fifo_core.sv
// -----------------------------------------------------------------------------
// tb_sample_fifo_core
// Directed and randomized stimulus for sample_fifo_core, checked against a
// queue-based reference model after every clock.
// -----------------------------------------------------------------------------
module tb_sample_fifo_core;

   localparam int unsigned DEPTH = 64;

   logic        clk;
   logic        reset;
   logic        cs;
   logic        read;
   logic        write;
   logic [4:0]  addr;
   logic [31:0] rd_data;
   logic [31:0] wr_data;
   logic [15:0] din;
   logic        din_valid;

   int n_pass;
   int n_total;

   // Reference model state
   logic [15:0] mq[$];
   bit          m_en;
   logic [15:0] m_dec;
   logic [15:0] m_cnt;
   bit          m_ovf;

   sample_fifo_core #(.FIFO_DEPTH_BIT(6)) dut (
      .clk       (clk),
      .reset     (reset),
      .cs        (cs),
      .read      (read),
      .write     (write),
      .addr      (addr),
      .rd_data   (rd_data),
      .wr_data   (wr_data),
      .din       (din),
      .din_valid (din_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      logic [6:0]  lvl;
      s   = '0;
      lvl = 7'(mq.size());
      if (mq.size() != 0) s[15:0] = mq[0];
      s[16]    = (mq.size() == 0);
      s[17]    = (mq.size() == DEPTH);
      s[18]    = m_ovf;
      s[26:20] = lvl;
      return s;
   endfunction

   function automatic logic [31:0] exp_ctrl();
      return {m_dec, 15'b0, m_en};
   endfunction

   // Behavioural update of the model for one clock edge
   task automatic model(input bit r, input bit c, input bit w, input logic [4:0] a,
                        input logic [31:0] wd, input logic [15:0] d, input bit dv);
      int  pre;
      bit  do_pop;
      bit  sampled;
      if (r) begin
         mq.delete();
         m_en = 0; m_dec = '0; m_cnt = '0; m_ovf = 0;
         return;
      end
      if (c && w && a[1:0] == 2'd3) begin
         mq.delete();
         m_ovf = 0; m_cnt = '0;
         return;
      end
      pre     = mq.size();
      do_pop  = c && w && a[1:0] == 2'd2 && pre > 0;
      sampled = 0;
      if (c && w && a[1:0] == 2'd1) begin
         m_en  = wd[0];
         m_dec = wd[31:16];
         m_cnt = '0;
      end else if (m_en && dv) begin
         if (m_cnt == m_dec) begin
            m_cnt   = '0;
            sampled = 1;
         end else begin
            m_cnt = m_cnt + 16'd1;
         end
      end
      if (do_pop) void'(mq.pop_front());
      if (sampled) begin
         if (pre < DEPTH || do_pop) mq.push_back(d);
         else m_ovf = 1;
      end
   endtask

   // One clock: drive inputs, model the edge, then read back STATUS
   task automatic step(input bit r, input bit c, input bit w, input logic [4:0] a,
                       input logic [31:0] wd, input logic [15:0] d, input bit dv);
      reset = r; cs = c; write = w; read = 1'b0; addr = a;
      wr_data = wd; din = d; din_valid = dv;
      @(posedge clk);
      model(r, c, w, a, wd, d, dv);
      #1;
      reset = 1'b0; cs = 1'b1; read = 1'b1; write = 1'b0; din_valid = 1'b0; addr = 5'd0;
      #1;
      chk("status", rd_data, exp_status());
   endtask

   task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
      cs = 1'b1; read = 1'b1; write = 1'b0; addr = a;
      #1;
      chk(tag, rd_data, exp);
   endtask

   task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
      step(0, 1, 1, a, d, 16'h0, 0);
   endtask

   task automatic sample(input logic [15:0] d);
      step(0, 0, 0, 5'd0, 32'h0, d, 1);
   endtask

   initial begin
      int          lvl;
      int          pushed;
      bit          dp;
      bit          dq;
      logic [4:0]  a;
      logic [31:0] wd;

      n_pass = 0; n_total = 0;
      reset = 1'b1; cs = 0; read = 0; write = 0; addr = '0;
      wr_data = '0; din = '0; din_valid = 0;
      m_en = 0; m_dec = '0; m_cnt = '0; m_ovf = 0;

      // Reset state
      step(1, 0, 0, 5'd0, 32'h0, 16'h0, 0);
      step(1, 0, 0, 5'd0, 32'h0, 16'h0, 0);
      chk("reset_status", rd_data, 32'h0001_0000);
      chk_reg("reset_ctrl", 5'd1, 32'h0);
      chk_reg("read_pop_addr", 5'd2, 32'h0);

      // din_valid ignored while disabled
      sample(16'h7777);
      chk("disabled_capture", rd_data, 32'h0001_0000);

      // Basic capture and pop
      wr_reg(5'd1, 32'h0000_0001);
      chk_reg("ctrl_readback", 5'd1, 32'h0000_0001);
      sample(16'h1111);
      chk("first_latency", rd_data, 32'h0010_1111);
      sample(16'h2222);
      sample(16'h3333);
      chk("basic_level3", rd_data, 32'h0030_1111);
      wr_reg(5'd2, 32'h0);
      chk("pop1", rd_data, 32'h0020_2222);
      wr_reg(5'd2, 32'h0);
      chk("pop2", rd_data, 32'h0010_3333);
      wr_reg(5'd2, 32'h0);
      chk("pop3_empty", rd_data, 32'h0001_0000);
      wr_reg(5'd2, 32'h0);
      chk("pop_when_empty", rd_data, 32'h0001_0000);

      // Decimation by 3
      wr_reg(5'd1, 32'h0002_0001);
      for (int i = 0; i < 9; i++) sample(16'(i));
      chk("decim_head", rd_data, 32'h0030_0002);
      wr_reg(5'd2, 32'h0);
      chk("decim_second", rd_data, 32'h0020_0005);
      wr_reg(5'd2, 32'h0);
      chk("decim_third", rd_data, 32'h0010_0008);
      chk_reg("decim_ctrl", 5'd1, 32'h0002_0001);
      chk_reg("read_clear_addr", 5'd3, 32'h0);

      // Full and overflow
      wr_reg(5'd3, 32'hFFFF_FFFF);
      wr_reg(5'd1, 32'h0000_0001);
      for (int i = 0; i < 65; i++) sample(16'(32'h100 + i));
      chk("full_overflow", rd_data, 32'h0406_0100);
      wr_reg(5'd0, 32'hFFFF_FFFF);
      chk("addr0_write_noop", rd_data, 32'h0406_0100);
      wr_reg(5'd3, 32'h0);
      chk("clear_after_full", rd_data, 32'h0001_0000);

      // Simultaneous push and pop while full
      for (int i = 0; i < 64; i++) sample(16'(32'h200 + i));
      step(0, 1, 1, 5'd2, 32'h0, 16'hBEEF, 1);
      chk("full_push_pop", rd_data, 32'h0402_0201);
      for (int i = 0; i < 63; i++) wr_reg(5'd2, 32'h0);
      chk("newest_at_tail", rd_data, 32'h0010_BEEF);

      // Simultaneous push and pop while empty
      wr_reg(5'd3, 32'h0);
      step(0, 1, 1, 5'd2, 32'h0, 16'hCAFE, 1);
      chk("empty_push_pop", rd_data, 32'h0010_CAFE);

      // CTRL write and CLEAR each swallow a coincident sample
      step(0, 1, 1, 5'd1, 32'h0000_0001, 16'h1234, 1);
      chk("ctrl_vs_capture", rd_data, 32'h0010_CAFE);
      step(0, 1, 1, 5'd3, 32'h0, 16'h5555, 1);
      chk("clear_vs_capture", rd_data, 32'h0001_0000);

      // Upper address bits ignored
      step(0, 1, 1, 5'b10101, 32'h0003_0001, 16'h0, 0);
      chk_reg("alias_ctrl", 5'b11101, 32'h0003_0001);

      // Wrap-around with level held between 10 and 30
      wr_reg(5'd3, 32'h0);
      wr_reg(5'd1, 32'h0000_0001);
      for (int i = 0; i < 20; i++) sample(16'($urandom));
      pushed = 0;
      for (int it = 0; it < 3000 && pushed < 200; it++) begin
         lvl = mq.size();
         dp  = (lvl < 30) && ($urandom_range(0, 2) != 0);
         dq  = (lvl > 10) && (($urandom_range(0, 2) != 0) || lvl >= 30);
         step(0, dq, dq, 5'd2, 32'h0, 16'($urandom), dp);
         if (dp) pushed++;
      end
      chk("wrap_no_overflow", 32'(rd_data[18]), 32'h0);

      // Randomized register traffic and sample stream
      for (int it = 0; it < 600; it++) begin
         a = 5'($urandom);
         if (a[1:0] == 2'd3 && $urandom_range(0, 15) != 0) a[1:0] = 2'd2;
         if (a[1:0] == 2'd1)
            wd = {16'($urandom_range(0, 3)), 15'($urandom), 1'($urandom_range(0, 3) != 0)};
         else
            wd = $urandom;
         step(0, 1'($urandom), 1'($urandom_range(0, 2) == 0), a, wd,
              16'($urandom), 1'($urandom_range(0, 3) != 0));
         if (it % 16 == 0) chk_reg("rand_ctrl", 5'd1, exp_ctrl());
      end

      // Reset mid-fill
      wr_reg(5'd3, 32'h0);
      wr_reg(5'd1, 32'h0000_0001);
      for (int i = 0; i < 20; i++) sample(16'(32'h400 + i));
      chk("prefill_level20", rd_data, 32'h0140_0400);
      step(1, 0, 0, 5'd0, 32'h0, 16'h9999, 1);
      chk("midreset_status", rd_data, 32'h0001_0000);
      chk_reg("midreset_ctrl", 5'd1, 32'h0);
      for (int i = 0; i < 5; i++) sample(16'(32'h500 + i));
      chk("post_reset_ignored", rd_data, 32'h0001_0000);
      wr_reg(5'd1, 32'h0000_0001);
      sample(16'hABCD);
      chk("reenable_capture", rd_data, 32'h0010_ABCD);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sample_fifo_core.md
SAMPLE_FIFO_CORE -- requirements
Module: sample_fifo_core

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH_BIT, default 6, meaning FIFO depth = 2**FIFO_DEPTH_BIT 16-bit entries.
REQ-002 Port list, one clock domain; reset is synchronous and active-high:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- cs  input  1  slot select
- read  input  1  slot read strobe (no side effect)
- write  input  1  slot write strobe
- addr  input  5  slot register address
- rd_data  output  32  slot read data, combinational from registered state
- wr_data  input  32  slot write data
- din  input  16  sample stream data (e.g. XADC/PCM producer)
- din_valid  input  1  one-cycle sample strobe

Function
REQ-003 Register writes SHALL take effect only when cs=1 and write=1; addr[1:0] decodes the register, addr[4:2] are ignored.
REQ-004 Write addr 1 (CTRL) SHALL load enable=wr_data[0] and decim=wr_data[31:16], and SHALL clear the decimation counter to 0.
REQ-005 Write addr 2 (POP) SHALL remove the head entry; POP when empty SHALL be ignored.
REQ-006 Write addr 3 (CLEAR) SHALL empty the FIFO, clear the overflow flag and zero the decimation counter; wr_data is ignored.
REQ-007 Write addr 0 SHALL have no effect.
REQ-008 Read addr 0 (STATUS) SHALL return: [15:0] head data (0 when empty), [16] empty, [17] full, [18] overflow, [19] 0, [20+FIFO_DEPTH_BIT:20] level, remaining bits 0.
REQ-009 Read addr 1 SHALL return {decim, 15'b0, enable}; reads of addr 2 and 3 SHALL return 0.
REQ-010 Decimation: when enable=1 and din_valid=1, if counter==decim the sample SHALL be pushed and counter set to 0, else counter increments; decim=0 captures every valid sample.
REQ-011 When enable=0, din_valid SHALL be ignored and the counter held.
REQ-012 Capture latency: a sample pushed on the edge where din_valid=1 SHALL be visible in STATUS (level, head if previously empty) on the following cycle.
REQ-013 Storage SHALL be a circular buffer with read and write pointers of FIFO_DEPTH_BIT bits wrapping from 2**FIFO_DEPTH_BIT-1 to 0; level is FIFO_DEPTH_BIT+1 bits.
REQ-014 Push while full and no POP same cycle: sample SHALL be dropped, contents unchanged, overflow set (sticky until CLEAR or reset).
REQ-015 Push and POP same cycle, non-empty: both SHALL occur, level unchanged (includes full case, no overflow).
REQ-016 Push and POP same cycle when empty: POP ignored, push succeeds, level becomes 1.
REQ-017 CLEAR coinciding with a capture SHALL win: FIFO empty, sample discarded, counter 0.
REQ-018 CTRL write coinciding with din_valid SHALL apply the new decim/enable and zero the counter; that sample SHALL NOT be pushed.
REQ-019 FIFO order SHALL be strict first-in first-out; entries SHALL never be duplicated or reordered.

Reset
REQ-020 On reset=1 at a clock edge: enable=0, decim=0, counter=0, pointers=0, level=0, overflow=0; STATUS reads 0x0001_0000.
REQ-021 Reset asserted mid-operation SHALL discard all stored samples; storage array contents need no reset.
REQ-022 rd_data SHALL depend only on addr and registered state, never on din/din_valid directly.

Verification
REQ-023 Basic: CTRL=0x0000_0001, drive din 0x1111,0x2222,0x3333 valid -> STATUS level 3, head 0x1111; POP x3 -> heads 0x2222,0x3333, then STATUS 0x0001_0000.
REQ-024 Decimation: CTRL=0x0002_0001, 9 valid samples 0..8 -> FIFO holds 2,5,8 in order.
REQ-025 Full/overflow (depth 64): push 65 samples, no POP -> full=1, overflow=1, level 64, head = first sample; CLEAR -> empty=1, overflow=0.
REQ-026 Simultaneous: FIFO full, POP and din_valid same cycle -> level stays 64, overflow stays 0, newest sample at tail; FIFO empty, POP+push -> level 1.
REQ-027 Wrap-around: push/pop 200 samples keeping level 10-30 -> sequence read equals sequence written, no overflow.
REQ-028 Reset mid-fill: level 20, assert reset one cycle -> STATUS 0x0001_0000, CTRL reads 0, subsequent din_valid ignored until enable set.
